// File: rtl/rdma_qp_arb.sv
// rdma_qp_arb: packet-atomic round-robin arbiter in front of rdma_sched.
// One queue pair owns the scheduler input for a whole packet. Accepted beats
// are forwarded one cycle later on sched_in_*. After each packet there is one
// arbitration cycle (S_GAP), so the scheduler always sees an idle cycle after
// a last beat. Packets longer than MAX_BEATS are cut at MAX_BEATS: that beat
// goes out with last forced high, and the rest of the packet is drained.
// Optional build macro: RDMA_QP_ARB_PRIO_EN makes QP0 strict priority; the
// remaining QPs round-robin among themselves.
module rdma_qp_arb #(
  parameter int NUM_QP    = 4,
  parameter int DATA_W    = 64,
  parameter int MAX_BEATS = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_QP-1:0]         qp_valid,
  input  logic [NUM_QP*DATA_W-1:0]  qp_data,
  input  logic [NUM_QP-1:0]         qp_last,
  output logic [NUM_QP-1:0]         qp_ready,
  output logic                      sched_in_valid,
  output logic [DATA_W-1:0]         sched_in_data,
  output logic                      sched_in_last,
  output logic [$clog2(NUM_QP)-1:0] grant_id,
  output logic                      err_long
);

  localparam int GW = $clog2(NUM_QP);
  localparam int CW = $clog2(MAX_BEATS + 1);
  localparam logic [CW-1:0] LAST_IDX = CW'(MAX_BEATS - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GAP   = 2'd1,
    S_XFER  = 2'd2,
    S_FLUSH = 2'd3
  } state_t;

  // State and registered datapath
  state_t             r_state;
  logic [GW-1:0]      r_grant_id;
  logic [GW-1:0]      r_rr_ptr;
  logic [CW-1:0]      r_beat_cnt;
  logic               r_out_valid;
  logic [DATA_W-1:0]  r_out_data;
  logic               r_out_last;
  logic               r_err_long;

  // Combinational decisions
  state_t             w_state_next;
  logic [NUM_QP-1:0]  w_req;
  logic               w_found;
  logic [GW-1:0]      w_rr_winner;
  logic [GW-1:0]      w_winner;
  logic               w_rr_upd;
  logic               w_sel_valid;
  logic               w_sel_last;
  logic [DATA_W-1:0]  w_sel_data;
  logic [NUM_QP-1:0]  w_ready;
  logic               w_arb_go;
  logic               w_emit;
  logic               w_trunc;

  // Beat presented by the currently granted QP
  assign w_sel_valid = qp_valid[r_grant_id];
  assign w_sel_last  = qp_last[r_grant_id];
  assign w_sel_data  = qp_data[int'(r_grant_id)*DATA_W +: DATA_W];

  // Arbitration: first requester after rr_ptr wins, wrapping around
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    w_req       = qp_valid;
    w_rr_upd    = 1'b1;
`ifdef RDMA_QP_ARB_PRIO_EN
    // QP0 is handled by the override below, never by the rotation.
    w_req[0]    = 1'b0;
`endif
    w_found     = 1'b0;
    w_rr_winner = '0;
    for (int k = 1; k <= NUM_QP; k++) begin
      if (!w_found && w_req[(int'(r_rr_ptr) + k) % NUM_QP]) begin
        w_found     = 1'b1;
        w_rr_winner = GW'((int'(r_rr_ptr) + k) % NUM_QP);
      end
    end
    w_winner = w_rr_winner;
`ifdef RDMA_QP_ARB_PRIO_EN
    // Strict priority win leaves the rotation pointer where it was.
    if (qp_valid[0]) begin
      w_found  = 1'b1;
      w_winner = '0;
      w_rr_upd = 1'b0;
    end
`endif
  end

  // FSM state register
  always_ff @(posedge clk) begin
    // NOTE: sequential state is always written with non-blocking assignments
    // so every register samples pre-edge values regardless of block order.
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_next;
  end

  // FSM next-state and handshake decode
  always_comb begin
    w_state_next = r_state;
    w_ready      = '0;
    w_arb_go     = 1'b0;
    w_emit       = 1'b0;
    w_trunc      = 1'b0;
    unique case (r_state)
      S_IDLE, S_GAP: begin
        if (w_found) begin
          w_arb_go     = 1'b1;
          w_state_next = S_XFER;
        end else begin
          w_state_next = S_IDLE;
        end
      end
      S_XFER: begin
        w_ready[r_grant_id] = 1'b1;
        if (w_sel_valid) begin
          w_emit = 1'b1;
          if (w_sel_last) begin
            w_state_next = S_GAP;
          end else if (r_beat_cnt == LAST_IDX) begin
            w_trunc      = 1'b1;
            w_state_next = S_FLUSH;
          end
        end
      end
      S_FLUSH: begin
        // Tail of a truncated packet: accept and drop until its last beat.
        w_ready[r_grant_id] = 1'b1;
        if (w_sel_valid && w_sel_last) w_state_next = S_GAP;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // Grant, round-robin pointer, beat counter and registered output stage
  always_ff @(posedge clk) begin
    if (rst) begin
      r_grant_id  <= '0;
      r_rr_ptr    <= GW'(NUM_QP - 1);
      r_beat_cnt  <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_last  <= 1'b0;
      r_err_long  <= 1'b0;
    end else begin
      r_out_valid <= w_emit;
      r_err_long  <= w_trunc;
      if (w_arb_go) begin
        r_grant_id <= w_winner;
        r_beat_cnt <= '0;
        if (w_rr_upd) r_rr_ptr <= w_winner;
      end
      // Data and last hold their value while no beat is emitted.
      if (w_emit) begin
        r_out_data <= w_sel_data;
        r_out_last <= w_sel_last | w_trunc;
        r_beat_cnt <= r_beat_cnt + CW'(1);
      end
    end
  end

  assign qp_ready       = w_ready;
  assign sched_in_valid = r_out_valid;
  assign sched_in_data  = r_out_data;
  assign sched_in_last  = r_out_last;
  assign grant_id       = r_grant_id;
  assign err_long       = r_err_long;

endmodule

// File: tb/tb_rdma_qp_arb.sv
// Testbench for rdma_qp_arb. Queue-pair sources replay per-QP packet-length
// queues with random data and (optionally) random valid gaps. A packet-level
// reference model predicts grants, readies and the delayed output stream.
module tb_rdma_qp_arb;

  localparam int NUM_QP    = 4;
  localparam int DATA_W    = 64;
  localparam int MAX_BEATS = 16;
  localparam int GW        = $clog2(NUM_QP);

  logic                     clk = 1'b0;
  logic                     rst = 1'b1;
  logic [NUM_QP-1:0]        qp_valid = '0;
  logic [NUM_QP*DATA_W-1:0] qp_data = '0;
  logic [NUM_QP-1:0]        qp_last = '0;
  logic [NUM_QP-1:0]        qp_ready;
  logic                     sched_in_valid;
  logic [DATA_W-1:0]        sched_in_data;
  logic                     sched_in_last;
  logic [GW-1:0]            grant_id;
  logic                     err_long;

  rdma_qp_arb #(.NUM_QP(NUM_QP), .DATA_W(DATA_W), .MAX_BEATS(MAX_BEATS)) dut (
    .clk(clk), .rst(rst),
    .qp_valid(qp_valid), .qp_data(qp_data), .qp_last(qp_last), .qp_ready(qp_ready),
    .sched_in_valid(sched_in_valid), .sched_in_data(sched_in_data),
    .sched_in_last(sched_in_last), .grant_id(grant_id), .err_long(err_long)
  );

  always #5 clk = ~clk;

  int    total = 0;
  int    bad   = 0;
  string cur_test = "init";
  bit    chk_en = 1'b0;

  // Sources
  int                pkt_q[NUM_QP][$];
  int                beat_idx[NUM_QP];
  int                start_dly[NUM_QP];
  int                drop_beat[NUM_QP];
  int                drop_left[NUM_QP];
  logic [DATA_W-1:0] cur_data[NUM_QP];
  int                pct = 100;

  // Reference model: "arbitrating" or "inside a packet of QP m_grant"
  bit                m_arb;
  int                m_grant, m_rr, m_pos;
  logic              exp_valid, exp_last, exp_err;
  logic [DATA_W-1:0] exp_data;
  int                grant_log[$];

  // Observed output statistics
  int obs_beats, obs_err, obs_last, obs_first, obs_lastc, cyc;

  function automatic logic [DATA_W-1:0] rand_beat();
    return DATA_W'({$urandom(), $urandom()});
  endfunction

  // Round-robin rule: first requester after m_rr, wrapping
  function automatic int rr_pick(input logic [NUM_QP-1:0] req);
    for (int k = 1; k <= NUM_QP; k++)
      if (req[(m_rr + k) % NUM_QP]) return (m_rr + k) % NUM_QP;
    return -1;
  endfunction

  function automatic bit logs_equal(input int e[$]);
    if (grant_log.size() != e.size()) return 1'b0;
    foreach (e[i]) if (grant_log[i] != e[i]) return 1'b0;
    return 1'b1;
  endfunction

  function automatic bit all_empty();
    for (int i = 0; i < NUM_QP; i++) if (pkt_q[i].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_reset();
    m_arb = 1'b1; m_grant = 0; m_rr = NUM_QP - 1; m_pos = 0;
    exp_valid = 1'b0; exp_last = 1'b0; exp_err = 1'b0; exp_data = '0;
  endtask

  task automatic clear_src();
    for (int i = 0; i < NUM_QP; i++) begin
      pkt_q[i].delete();
      beat_idx[i] = 0; start_dly[i] = 0; drop_beat[i] = -1; drop_left[i] = 0;
      cur_data[i] = rand_beat();
    end
  endtask

  task automatic clear_obs();
    obs_beats = 0; obs_err = 0; obs_last = 0; obs_first = -1; obs_lastc = -1;
    grant_log.delete();
  endtask

  // One clock: drive sources, compare DUT against model, advance model
  task automatic run_cycle(input bit do_rst);
    logic [NUM_QP-1:0] exp_ready;
    logic [NUM_QP-1:0] req;
    bit have, stall, lastb;
    int w, g;
    @(negedge clk);
    rst = do_rst;
    for (int i = 0; i < NUM_QP; i++) begin
      have  = (pkt_q[i].size() > 0) && (start_dly[i] == 0);
      stall = have && (drop_left[i] > 0) && (beat_idx[i] == drop_beat[i]);
      qp_valid[i] = have && !stall && (int'($urandom_range(99)) < pct);
      qp_last[i]  = have ? (beat_idx[i] == pkt_q[i][0] - 1) : 1'b0;
      qp_data[i*DATA_W +: DATA_W] = cur_data[i];
      if (start_dly[i] > 0) start_dly[i]--;
      if (stall) drop_left[i]--;
    end
    #1;
    if (chk_en) begin
      exp_ready = '0;
      if (!m_arb) exp_ready[m_grant] = 1'b1;
      total++;
      if (qp_ready !== exp_ready) begin
        bad++; $display("FAIL %s/qp_ready cyc=%0d: got=%b want=%b", cur_test, cyc, qp_ready, exp_ready);
      end
      total++;
      if (sched_in_valid !== exp_valid) begin
        bad++; $display("FAIL %s/sched_valid cyc=%0d: got=%b want=%b", cur_test, cyc, sched_in_valid, exp_valid);
      end
      total++;
      if (sched_in_data !== exp_data) begin
        bad++; $display("FAIL %s/sched_data cyc=%0d: got=%h want=%h", cur_test, cyc, sched_in_data, exp_data);
      end
      total++;
      if (sched_in_last !== exp_last) begin
        bad++; $display("FAIL %s/sched_last cyc=%0d: got=%b want=%b", cur_test, cyc, sched_in_last, exp_last);
      end
      total++;
      if (grant_id !== GW'(m_grant)) begin
        bad++; $display("FAIL %s/grant_id cyc=%0d: got=%0d want=%0d", cur_test, cyc, grant_id, m_grant);
      end
      total++;
      if (err_long !== exp_err) begin
        bad++; $display("FAIL %s/err_long cyc=%0d: got=%b want=%b", cur_test, cyc, err_long, exp_err);
      end
    end
    if (sched_in_valid === 1'b1) begin
      obs_beats++;
      if (sched_in_last === 1'b1) obs_last++;
      if (obs_first < 0) obs_first = cyc;
      obs_lastc = cyc;
    end
    if (err_long === 1'b1) obs_err++;

    if (do_rst) begin
      model_reset();
    end else if (m_arb) begin
      exp_valid = 1'b0; exp_err = 1'b0;
      req = qp_valid;
`ifdef RDMA_QP_ARB_PRIO_EN
      if (req[0]) begin
        w = 0;
      end else begin
        w = rr_pick(req);
        if (w >= 0) m_rr = w;
      end
`else
      w = rr_pick(req);
      if (w >= 0) m_rr = w;
`endif
      if (w >= 0) begin
        m_arb = 1'b0; m_grant = w; m_pos = 0;
        grant_log.push_back(w);
      end
    end else begin
      exp_valid = 1'b0; exp_err = 1'b0;
      g = m_grant;
      if (qp_valid[g]) begin
        lastb = qp_last[g];
        m_pos++;
        if (m_pos <= MAX_BEATS) begin
          exp_valid = 1'b1;
          exp_data  = cur_data[g];
          exp_last  = lastb || (m_pos == MAX_BEATS);
          exp_err   = (m_pos == MAX_BEATS) && !lastb;
        end
        if (lastb) m_arb = 1'b1;
        beat_idx[g]++;
        cur_data[g] = rand_beat();
        if (lastb) begin
          void'(pkt_q[g].pop_front());
          beat_idx[g] = 0;
        end
      end
    end
    cyc++;
  endtask

  task automatic apply_reset();
    run_cycle(1'b1);
    chk_en = 1'b1;
    run_cycle(1'b1);
  endtask

  task automatic begin_test(input string name);
    cur_test = name;
    pct = 100;
    clear_src();
    apply_reset();
    clear_obs();
  endtask

  // Run until every source is drained and the model is back to arbitration
  task automatic wait_done(input int budget);
    int n = 0;
    while (!(all_empty() && m_arb) && n < budget) begin
      run_cycle(1'b0);
      n++;
    end
    total++;
    if (n >= budget) begin
      bad++; $display("FAIL %s/timeout: got=%0d cycles want=<%0d", cur_test, n, budget);
    end
    run_cycle(1'b0);
    run_cycle(1'b0);
  endtask

  task automatic test_reset();
    int q[$];
    int n = 0;
    begin_test("reset");
    run_cycle(1'b0);
    total++;
    if (qp_ready !== '0 || sched_in_valid !== 1'b0 || sched_in_last !== 1'b0 ||
        sched_in_data !== '0 || grant_id !== '0 || err_long !== 1'b0) begin
      bad++; $display("FAIL reset/initial: got ready=%b v=%b l=%b d=%h g=%0d e=%b want all 0",
                      qp_ready, sched_in_valid, sched_in_last, sched_in_data, grant_id, err_long);
    end
    // Reset in the middle of a 5-beat packet, while beat 2 is presented
    pkt_q[0].push_back(5);
    while (beat_idx[0] != 2 && n < 20) begin run_cycle(1'b0); n++; end
    total++;
    if (n >= 20) begin
      bad++; $display("FAIL reset/reach_beat2: got=%0d cycles want=<20", n);
    end
    run_cycle(1'b1);
    clear_src();
    run_cycle(1'b0);
    total++;
    if (qp_ready !== '0 || sched_in_valid !== 1'b0 || sched_in_last !== 1'b0 ||
        sched_in_data !== '0 || grant_id !== '0 || err_long !== 1'b0) begin
      bad++; $display("FAIL reset/mid_packet: got ready=%b v=%b l=%b d=%h g=%0d e=%b want all 0",
                      qp_ready, sched_in_valid, sched_in_last, sched_in_data, grant_id, err_long);
    end
    grant_log.delete();
    pkt_q[1].push_back(2);
    pkt_q[0].push_back(2);
    wait_done(100);
    q = '{0, 1};
    total++;
    if (!logs_equal(q)) begin
      bad++; $display("FAIL reset/post_release_order: got=%p want=%p", grant_log, q);
    end
  endtask

  task automatic test_order();
    int q[$];
    begin_test("order");
    for (int i = 0; i < NUM_QP; i++) pkt_q[i].push_back(3);
    wait_done(200);
    q = '{0, 1, 2, 3};
    total++;
    if (!logs_equal(q)) begin
      bad++; $display("FAIL order/grants: got=%p want=%p", grant_log, q);
    end
    total++;
    if (obs_beats != 12 || obs_last != 4) begin
      bad++; $display("FAIL order/beats: got beats=%0d lasts=%0d want 12/4", obs_beats, obs_last);
    end
  endtask

  task automatic test_back_to_back();
    begin_test("back_to_back");
    for (int i = 0; i < 8; i++) pkt_q[2].push_back(1);
    wait_done(200);
    total++;
    if (obs_beats != 8 || (obs_lastc - obs_first) != 14) begin
      bad++; $display("FAIL back_to_back/pattern: got beats=%0d span=%0d want 8/14",
                      obs_beats, obs_lastc - obs_first);
    end
  endtask

  task automatic test_long();
    int q[$];
    begin_test("long");
    pkt_q[1].push_back(20);
    pkt_q[2].push_back(2);
    wait_done(200);
    q = '{1, 2};
    total++;
    if (!logs_equal(q)) begin
      bad++; $display("FAIL long/grants: got=%p want=%p", grant_log, q);
    end
    total++;
    if (obs_beats != 18 || obs_last != 2 || obs_err != 1) begin
      bad++; $display("FAIL long/counts: got beats=%0d lasts=%0d errs=%0d want 18/2/1",
                      obs_beats, obs_last, obs_err);
    end
  endtask

  task automatic test_exact_max();
    begin_test("exact_max");
    pkt_q[0].push_back(MAX_BEATS);
    wait_done(200);
    total++;
    if (obs_beats != MAX_BEATS || obs_last != 1 || obs_err != 0) begin
      bad++; $display("FAIL exact_max/counts: got beats=%0d lasts=%0d errs=%0d want %0d/1/0",
                      obs_beats, obs_last, obs_err, MAX_BEATS);
    end
  endtask

  task automatic test_stall();
    int q[$];
    begin_test("stall");
    pkt_q[3].push_back(5);
    drop_beat[3] = 2; drop_left[3] = 3;
    pkt_q[0].push_back(2);
    start_dly[0] = 2;
    wait_done(200);
    q = '{3, 0};
    total++;
    if (!logs_equal(q)) begin
      bad++; $display("FAIL stall/grants: got=%p want=%p", grant_log, q);
    end
    total++;
    if (obs_beats != 7) begin
      bad++; $display("FAIL stall/beats: got=%0d want=7", obs_beats);
    end
  endtask

  task automatic test_prio();
    int q[$];
    begin_test("prio");
    for (int i = 0; i < 3; i++) begin
      pkt_q[0].push_back(2); pkt_q[1].push_back(2); pkt_q[2].push_back(2);
    end
    wait_done(300);
`ifdef RDMA_QP_ARB_PRIO_EN
    q = '{0, 0, 0, 1, 2, 1, 2, 1, 2};
`else
    q = '{0, 1, 2, 0, 1, 2, 0, 1, 2};
`endif
    total++;
    if (!logs_equal(q)) begin
      bad++; $display("FAIL prio/grants: got=%p want=%p", grant_log, q);
    end
  endtask

  task automatic test_random();
    int len, want_beats, want_err;
    begin_test("random");
    pct = 60;
    want_beats = 0; want_err = 0;
    for (int i = 0; i < NUM_QP; i++) begin
      for (int p = 0; p < 4; p++) begin
        len = int'($urandom_range(20, 1));
        pkt_q[i].push_back(len);
        want_beats += (len > MAX_BEATS) ? MAX_BEATS : len;
        if (len > MAX_BEATS) want_err++;
      end
    end
    wait_done(3000);
    total++;
    if (obs_beats != want_beats || obs_err != want_err || obs_last != 4 * NUM_QP) begin
      bad++; $display("FAIL random/counts: got beats=%0d errs=%0d lasts=%0d want %0d/%0d/%0d",
                      obs_beats, obs_err, obs_last, want_beats, want_err, 4 * NUM_QP);
    end
  endtask

  initial begin
    cyc = 0;
    clear_src();
    model_reset();
    clear_obs();
    test_reset();
    test_order();
    test_back_to_back();
    test_long();
    test_exact_max();
    test_stall();
    test_prio();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
